// File: rtl/alu_compare_unit_if.sv
// Operand/result bundle between the EXE stage and alu_compare_unit.
// The master drives the operation; the slave returns results and HI/LO.
interface alu_compare_unit_if;
  logic        alu_valid;
  logic        FREEZE;
  logic [5:0]  ALU_control;
  logic [31:0] Operand_A;
  logic [31:0] Operand_B;
  logic [4:0]  shamt;
  logic [31:0] Instr;
  logic [31:0] aluResult;
  logic        overflow;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        taken_branch;

  modport master (
    output alu_valid, FREEZE, ALU_control, Operand_A, Operand_B, shamt, Instr,
    input  aluResult, overflow, HI, LO, taken_branch
  );

  modport slave (
    input  alu_valid, FREEZE, ALU_control, Operand_A, Operand_B, shamt, Instr,
    output aluResult, overflow, HI, LO, taken_branch
  );
endinterface

// File: rtl/alu_compare_unit.sv
// Single-cycle MIPS-style ALU with HI/LO registers and a signed branch comparator.
// Result, overflow and branch decision are combinational; only HI/LO are clocked.
module alu_compare_unit (
  input logic              CLK,
  input logic              RESET,
  alu_compare_unit_if.slave bus
);
  localparam logic [5:0] OP_SLL   = 6'h00, OP_SRL  = 6'h02, OP_SRA   = 6'h03;
  localparam logic [5:0] OP_SLLV  = 6'h04, OP_SRLV = 6'h06, OP_SRAV  = 6'h07;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_MFHI = 6'h10, OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12, OP_MTLO = 6'h13, OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19, OP_DIV  = 6'h1A, OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20, OP_ADDU = 6'h21, OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23, OP_AND  = 6'h24, OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26, OP_NOR  = 6'h27, OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  localparam logic [5:0] BR_REGIMM = 6'h01, BR_BEQ = 6'h04, BR_BNE  = 6'h05;
  localparam logic [5:0] BR_BLEZ   = 6'h06, BR_BGTZ = 6'h07;

  logic [31:0] a, b;
  logic [31:0] sum, diff;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, quot_u, rem_u;
  logic [31:0] mag_a, mag_b, mag_div, quot_m, rem_m, quot_s, rem_s;
  logic [31:0] result_c;
  logic        ovf_c;
  logic        taken_c;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic [5:0]  br_op;
  logic [4:0]  br_rt;
  logic        unused_instr;

  assign a    = bus.Operand_A;
  assign b    = bus.Operand_B;
  assign sum  = a + b;
  assign diff = a - b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divisors are forced nonzero; the divide-by-zero result is substituted below.
  assign div_b  = (b == 32'd0) ? 32'd1 : b;
  assign quot_u = a / div_b;
  assign rem_u  = a % div_b;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign mag_a   = a[31] ? (~a + 32'd1) : a;
  assign mag_b   = b[31] ? (~b + 32'd1) : b;
  assign mag_div = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign quot_m  = mag_a / mag_div;
  assign rem_m   = mag_a % mag_div;
  assign quot_s  = (a[31] ^ b[31]) ? (~quot_m + 32'd1) : quot_m;
  assign rem_s   = a[31] ? (~rem_m + 32'd1) : rem_m;

  always_comb begin
    result_c = 32'd0;
    ovf_c    = 1'b0;
    case (bus.ALU_control)
      OP_ADD:   begin result_c = sum;  ovf_c = (a[31] == b[31]) && (sum[31] != a[31]); end
      OP_ADDU:  result_c = sum;
      OP_SUB:   begin result_c = diff; ovf_c = (a[31] != b[31]) && (diff[31] != a[31]); end
      OP_SUBU:  result_c = diff;
      OP_AND:   result_c = a & b;
      OP_OR:    result_c = a | b;
      OP_XOR:   result_c = a ^ b;
      OP_NOR:   result_c = ~(a | b);
      OP_SLT:   result_c = {31'b0, ($signed(a) < $signed(b))};
      OP_SLTU:  result_c = {31'b0, (a < b)};
      OP_SLL:   result_c = b << bus.shamt;
      OP_SRL:   result_c = b >> bus.shamt;
      OP_SRA:   result_c = $signed(b) >>> bus.shamt;
      OP_SLLV:  result_c = b << a[4:0];
      OP_SRLV:  result_c = b >> a[4:0];
      OP_SRAV:  result_c = $signed(b) >>> a[4:0];
      OP_LUI:   result_c = {b[15:0], 16'h0000};
      OP_MFHI:  result_c = hi_q;
      OP_MFLO:  result_c = lo_q;
      OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: result_c = a;
      default:  result_c = 32'd0;
    endcase
  end

  assign br_op        = bus.Instr[31:26];
  assign br_rt        = bus.Instr[20:16];
  assign unused_instr = ^{bus.Instr[25:21], bus.Instr[15:0]};

  always_comb begin
    taken_c = 1'b0;
    case (br_op)
      BR_BEQ:  taken_c = (a == b);
      BR_BNE:  taken_c = (a != b);
      BR_BLEZ: taken_c = a[31] || (a == 32'd0);
      BR_BGTZ: taken_c = !a[31] && (a != 32'd0);
      BR_REGIMM: begin
        if (br_rt == 5'h00 || br_rt == 5'h10)      taken_c = a[31];
        else if (br_rt == 5'h01 || br_rt == 5'h11) taken_c = !a[31];
        else                                       taken_c = 1'b0;
      end
      default: taken_c = 1'b0;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.alu_valid && !bus.FREEZE) begin
      case (bus.ALU_control)
        OP_MTHI:  hi_d = a;
        OP_MTLO:  lo_d = a;
        OP_MULT:  begin hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
        OP_MULTU: begin hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
        OP_DIV: begin
          hi_d = (b == 32'd0) ? a            : rem_s;
          lo_d = (b == 32'd0) ? 32'hFFFFFFFF : quot_s;
        end
        OP_DIVU: begin
          hi_d = (b == 32'd0) ? a            : rem_u;
          lo_d = (b == 32'd0) ? 32'hFFFFFFFF : quot_u;
        end
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.aluResult    = result_c;
  assign bus.overflow     = ovf_c;
  assign bus.taken_branch = taken_c;
  assign bus.HI           = hi_q;
  assign bus.LO           = lo_q;
endmodule

// File: tb/tb_alu_compare_unit.sv
// Directed and randomized checks of alu_compare_unit against an arithmetic reference model.
module tb_alu_compare_unit;
  logic CLK;
  logic RESET;
  alu_compare_unit_if bus ();

  alu_compare_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  logic [5:0] op_list [0:26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0F,
                                 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A,
                                 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h05, 6'h3F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_result(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           input logic [31:0] hi, input logic [31:0] lo);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return sb >>> sh;
      6'h04: return b << a[4:0];
      6'h06: return b >> a[4:0];
      6'h07: return sb >>> a[4:0];
      6'h0F: return b * 32'd65536;
      6'h10: return hi;
      6'h12: return lo;
      6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_ovf(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint r;
    sa = a;
    sb = b;
    if (op == 6'h20)      r = longint'(sa) + longint'(sb);
    else if (op == 6'h22) r = longint'(sa) - longint'(sb);
    else                  return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic m_branch(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    int sa;
    logic [5:0] op;
    logic [4:0] rt;
    sa = a;
    op = instr[31:26];
    rt = instr[20:16];
    case (op)
      6'h04: return a == b;
      6'h05: return a != b;
      6'h06: return sa <= 0;
      6'h07: return sa > 0;
      6'h01: begin
        if (rt == 5'h00 || rt == 5'h10) return sa < 0;
        if (rt == 5'h01 || rt == 5'h11) return sa >= 0;
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_edge(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic v, input logic f, input logic r);
    int sa, sb;
    longint p, q, rm;
    longint unsigned ua, ub, pu;
    sa = a;
    sb = b;
    ua = a;
    ub = b;
    if (r) begin
      m_hi = 0;
      m_lo = 0;
    end else if (v && !f) begin
      case (op)
        6'h11: m_hi = a;
        6'h13: m_lo = a;
        6'h18: begin p = longint'(sa) * longint'(sb); m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h19: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
        6'h1A, 6'h1B: begin
          if (b == 0) begin
            m_hi = a;
            m_lo = 32'hFFFFFFFF;
          end else if (op == 6'h1A) begin
            q  = longint'(sa) / longint'(sb);
            rm = longint'(sa) % longint'(sb);
            m_lo = q[31:0];
            m_hi = rm[31:0];
          end else begin
            pu = ua / ub;
            m_lo = pu[31:0];
            pu = ua % ub;
            m_hi = pu[31:0];
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] instr,
                      input logic v, input logic f, input logic r);
    @(negedge CLK);
    bus.ALU_control = op;
    bus.Operand_A   = a;
    bus.Operand_B   = b;
    bus.shamt       = sh;
    bus.Instr       = instr;
    bus.alu_valid   = v;
    bus.FREEZE      = f;
    RESET           = r;
    #1;
    check($sformatf("result op=%h", op), bus.aluResult, m_result(op, a, b, sh, m_hi, m_lo));
    check($sformatf("overflow op=%h", op), {31'b0, bus.overflow}, {31'b0, m_ovf(op, a, b)});
    check($sformatf("branch instr=%h", instr), {31'b0, bus.taken_branch}, {31'b0, m_branch(instr, a, b)});
    m_edge(op, a, b, v, f, r);
    @(posedge CLK);
    #1;
    check($sformatf("HI op=%h", op), bus.HI, m_hi);
    check($sformatf("LO op=%h", op), bus.LO, m_lo);
  endtask

  function automatic logic [31:0] br(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd0, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] rop;
    logic [5:0] bop;
    logic [4:0] brt;
    logic [31:0] rinstr;
    RESET = 1'b1;
    bus.ALU_control = 6'h00; bus.Operand_A = 0; bus.Operand_B = 0; bus.shamt = 0;
    bus.Instr = 0; bus.alu_valid = 0; bus.FREEZE = 0;

    step(6'h00, 0, 0, 0, 0, 0, 0, 1);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);

    step(6'h20, 32'h7FFFFFFF, 1, 0, 0, 1, 0, 0);
    check("add_res", bus.aluResult, 32'h80000000);
    check("add_ovf", {31'b0, bus.overflow}, 32'd1);
    step(6'h21, 32'h7FFFFFFF, 1, 0, 0, 1, 0, 0);
    check("addu_ovf", {31'b0, bus.overflow}, 32'd0);
    step(6'h22, 32'h80000000, 1, 0, 0, 1, 0, 0);
    check("sub_ovf", {31'b0, bus.overflow}, 32'd1);
    step(6'h2A, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0);
    check("slt", bus.aluResult, 32'd1);
    step(6'h2B, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0);
    check("sltu", bus.aluResult, 32'd0);
    step(6'h03, 0, 32'h80000000, 5'd4, 0, 1, 0, 0);
    check("sra", bus.aluResult, 32'hF8000000);
    step(6'h06, 32'h24, 32'hF0, 0, 0, 1, 0, 0);
    check("srlv", bus.aluResult, 32'h0F);
    step(6'h0F, 0, 32'h1234, 0, 0, 1, 0, 0);
    check("lui", bus.aluResult, 32'h12340000);
    step(6'h10, 0, 0, 0, 0, 1, 0, 0);
    check("mfhi_reset", bus.aluResult, 32'd0);

    step(6'h18, 32'hFFFFFFFE, 3, 0, 0, 1, 0, 0);
    check("mult_hi", bus.HI, 32'hFFFFFFFF);
    check("mult_lo", bus.LO, 32'hFFFFFFFA);
    step(6'h18, 5, 7, 0, 0, 1, 1, 0);
    check("freeze_hi", bus.HI, 32'hFFFFFFFF);
    check("freeze_lo", bus.LO, 32'hFFFFFFFA);
    step(6'h19, 32'hFFFFFFFF, 2, 0, 0, 0, 0, 0);
    check("novalid_lo", bus.LO, 32'hFFFFFFFA);
    step(6'h12, 0, 0, 0, 0, 1, 0, 0);
    check("mflo_after_mult", bus.aluResult, 32'hFFFFFFFA);

    step(6'h1A, 32'hFFFFFFF9, 2, 0, 0, 1, 0, 0);
    check("div_lo", bus.LO, 32'hFFFFFFFD);
    check("div_hi", bus.HI, 32'hFFFFFFFF);
    step(6'h1B, 7, 0, 0, 0, 1, 0, 0);
    check("divu0_lo", bus.LO, 32'hFFFFFFFF);
    check("divu0_hi", bus.HI, 32'd7);
    step(6'h1A, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 0, 0);
    check("divovf_lo", bus.LO, 32'h80000000);
    check("divovf_hi", bus.HI, 32'd0);
    step(6'h13, 32'h55, 0, 0, 0, 1, 0, 0);
    step(6'h12, 0, 0, 0, 0, 1, 0, 0);
    check("mtlo_mflo", bus.aluResult, 32'h55);
    step(6'h11, 32'hABCD, 0, 0, 0, 1, 0, 0);
    check("mthi_hi", bus.HI, 32'hABCD);
    check("mthi_lo_kept", bus.LO, 32'h55);

    step(6'h21, 5, 5, 0, br(6'h04, 0), 0, 0, 0);
    check("beq", {31'b0, bus.taken_branch}, 32'd1);
    step(6'h21, 5, 5, 0, br(6'h05, 0), 0, 0, 0);
    check("bne", {31'b0, bus.taken_branch}, 32'd0);
    step(6'h21, 0, 9, 0, br(6'h06, 0), 0, 0, 0);
    check("blez", {31'b0, bus.taken_branch}, 32'd1);
    step(6'h21, 32'h80000000, 0, 0, br(6'h07, 0), 0, 0, 0);
    check("bgtz", {31'b0, bus.taken_branch}, 32'd0);
    step(6'h21, 0, 0, 0, br(6'h01, 5'h11), 0, 0, 0);
    check("bgezal", {31'b0, bus.taken_branch}, 32'd1);
    step(6'h21, 0, 0, 0, br(6'h23, 0), 0, 0, 0);
    check("br_other", {31'b0, bus.taken_branch}, 32'd0);

    step(6'h18, 32'h12345, 32'h6789, 0, 0, 1, 0, 0);
    step(6'h18, 32'hFFFFFFFE, 3, 0, 0, 1, 0, 1);
    check("rst_mult_hi", bus.HI, 32'd0);
    check("rst_mult_lo", bus.LO, 32'd0);

    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : op_list[$urandom_range(0, 26)];
      case ($urandom_range(0, 6))
        0: bop = 6'h01;
        1: bop = 6'h04;
        2: bop = 6'h05;
        3: bop = 6'h06;
        4: bop = 6'h07;
        default: bop = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 4))
        0: brt = 5'h00;
        1: brt = 5'h01;
        2: brt = 5'h10;
        3: brt = 5'h11;
        default: brt = 5'($urandom_range(0, 31));
      endcase
      rinstr = $urandom;
      rinstr[31:26] = bop;
      rinstr[20:16] = brt;
      step(rop, rnd32(), rnd32(), 5'($urandom_range(0, 31)), rinstr,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_compare_unit.md
# alu_compare_unit

Single-cycle integer execute datapath for the out-of-order core's EXE stage. It combines a MIPS-style ALU (with architectural HI/LO registers) and a branch-condition comparator. The ALU result and the branch decision are combinational. Only HI/LO are state, updated on the clock edge. EXE instantiates it for the main ALU, the AGU (address add) and branch resolution.

## Interface
- No parameters; all datapaths fixed at 32 bits.
- CLK  in  1  clock; HI/LO update on rising edge.
- RESET  in  1  synchronous, active-high; clears HI/LO.
- alu_valid  in  1  instruction present this cycle; gates HI/LO writes.
- FREEZE  in  1  pipeline stall; when 1, HI/LO hold.
- ALU_control  in  6  operation code (MIPS funct encoding, below).
- Operand_A  in  32  rs operand.
- Operand_B  in  32  rt operand or immediate.
- shamt  in  5  shift amount for fixed shifts (Instr[10:6]).
- Instr  in  32  instruction word, for branch decode.
- aluResult  out  32  combinational result.
- overflow  out  1  signed overflow flag for ADD/SUB.
- HI  out  32  current HI register.
- LO  out  32  current LO register.
- taken_branch  out  1  combinational branch-taken decision.

## Operation
ALU_control codes (A = Operand_A, B = Operand_B):
- 0x20 ADD / 0x21 ADDU: A+B, mod 2^32.
- 0x22 SUB / 0x23 SUBU: A−B.
- overflow = 1 only for ADD/SUB on signed overflow. There is no trap.
- 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise.
- 0x2A SLT: signed A<B gives 1, else 0.
- 0x2B SLTU: unsigned A<B gives 1, else 0.
- 0x00 SLL, 0x02 SRL, 0x03 SRA: B shifted by shamt.
- 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: B shifted by A[4:0].
- SRA and SRAV are arithmetic shifts.
- 0x0F LUI: {B[15:0],16'h0}.
- 0x10 MFHI: result = HI. 0x12 MFLO: result = LO.
- 0x11 MTHI: HI ← A. 0x13 MTLO: LO ← A.
- Result for MTHI/MTLO/MULT/MULTU/DIV/DIVU is A. This is a don't-care for the ROB.
- 0x18 MULT: signed 64-bit product; HI ← upper 32 bits, LO ← lower 32 bits.
- 0x19 MULTU: same as MULT, unsigned.
- 0x1A DIV: signed; LO ← quotient (truncated toward zero), HI ← remainder (sign of dividend).
- 0x1B DIVU: same as DIV, unsigned.
- Divide by zero: LO ← 0xFFFFFFFF, HI ← A.
- Signed DIV of 0x80000000 by −1: LO ← 0x80000000, HI ← 0.
- Any other code: aluResult = 0, overflow = 0, no HI/LO write.

Comparator decodes op = Instr[31:26] and rt = Instr[20:16]; all comparisons are signed:
- op 0x04 BEQ: A==B.
- op 0x05 BNE: A!=B.
- op 0x06 BLEZ: A<=0.
- op 0x07 BGTZ: A>0.
- op 0x01 REGIMM: rt 0x00 or 0x10 (BLTZ/BLTZAL) tests A<0; rt 0x01 or 0x11 (BGEZ/BGEZAL) tests A>=0.
- Any other op or rt: taken_branch = 0.

## Timing
- aluResult, overflow and taken_branch are purely combinational with zero latency. They are independent of alu_valid.
- HI and LO change only at a CLK rising edge.
- Edge priority: RESET=1 sets HI=LO=0 and has priority over everything.
- Otherwise, a write happens only if alu_valid=1, FREEZE=0 and the op is MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- MTHI and MTLO write only their own register.
- MFHI/MFLO return the pre-edge HI/LO value. A MULT followed by MFLO in the next cycle sees the new LO; there is no same-cycle bypass.
- A RESET asserted during a cycle in which a MULT is valid discards the product; HI=LO=0 afterwards.
- Reset values: HI=0, LO=0. The combinational outputs follow their inputs during reset.

## Test plan
- Arithmetic: ADD A=0x7FFFFFFF, B=1 gives aluResult=0x80000000, overflow=1. ADDU with the same operands gives the same result with overflow=0. SLT A=0xFFFFFFFF, B=1 gives 1; SLTU with the same operands gives 0.
- Shifts and LUI: SRA B=0x80000000, shamt=4 gives 0xF8000000. SRLV A=0x24, B=0xF0 gives 0x0F (uses A[4:0]=4). LUI B=0x1234 gives 0x12340000.
- HI/LO multiply: after RESET, MFHI gives 0. MULT A=−2, B=3, alu_valid=1, one edge, gives HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same MULT with FREEZE=1 leaves HI/LO unchanged.
- Division: DIV A=−7, B=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 gives LO=0xFFFFFFFF, HI=7. MTLO A=0x55 then MFLO gives 0x55.
- Branches: BEQ with A=B=5 gives 1. BNE with the same operands gives 0. BLEZ A=0 gives 1. BGTZ A=0x80000000 gives 0. REGIMM rt=0x11 with A=0 gives 1. Opcode 0x23 gives 0.
- Reset collision: MULT valid in the same cycle as RESET=1 gives HI=LO=0 after the edge.
